// File: rtl/fifo_push_arbiter_if.sv
// Handshake bundle between four producers, the push arbiter and a FIFO write port.
//   req        : per-producer level request, held until its ack pulse
//   req_data   : producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack        : one-hot, one-cycle pulse when the producer's word was written
//   grant      : one-hot winner of the transaction in progress, 0 when idle
//   fifo_push  : FIFO push strobe
//   fifo_data  : FIFO write data
//   fifo_busy  : FIFO busy flag (push or pop in progress)
//   fifo_full  : FIFO full flag
//   push_count : completed pushes, wraps at 16 bits
// Modport master is the arbiter side; slave is the producer/FIFO environment.
interface fifo_push_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REQ    = 4
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic [NUM_REQ-1:0]            grant;
   logic                          fifo_push;
   logic [DATA_WIDTH-1:0]         fifo_data;
   logic                          fifo_busy;
   logic                          fifo_full;
   logic [15:0]                   push_count;

   modport master (
      input  req, req_data, fifo_busy, fifo_full,
      output ack, grant, fifo_push, fifo_data, push_count
   );

   modport slave (
      output req, req_data, fifo_busy, fifo_full,
      input  ack, grant, fifo_push, fifo_data, push_count
   );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that lets one of four producers at a time push a word into a FIFO.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fifo_push_arbiter_if master modport (requests, acks, grant, FIFO write side)
// A transaction is IDLE -> ISSUE (one push cycle) -> WAIT (at least 3 cycles, until the
// FIFO is no longer busy) -> DONE (ack pulse) -> IDLE. All outputs are registered.
module fifo_push_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REQ    = 4
) (
   input logic                 clock,
   input logic                 reset,
   fifo_push_arbiter_if.master bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e                state_q, state_d;
   logic [1:0]            rr_ptr_q, rr_ptr_d;
   logic [1:0]            win_q, win_d;
   logic [1:0]            wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic                  push_q, push_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [15:0]           push_count_q, push_count_d;

   logic [1:0]            pick;
   logic                  pick_valid;

   // First set request searching upward from the producer after the last winner.
   always_comb begin : arbitrate
      logic [1:0] idx;
      idx        = '0;
      pick       = '0;
      pick_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = rr_ptr_q + 2'(i + 1);
         if (!pick_valid && bus.req[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin : next_state
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      win_d        = win_q;
      wait_cnt_d   = wait_cnt_q;
      grant_d      = grant_q;
      ack_d        = '0;
      push_d       = 1'b0;
      data_d       = data_q;
      push_count_d = push_count_q;

      unique case (state_q)
         StIdle: begin
            if (pick_valid && !bus.fifo_busy && !bus.fifo_full) begin
               state_d       = StIssue;
               win_d         = pick;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               data_d        = bus.req_data[pick*DATA_WIDTH +: DATA_WIDTH];
               push_d        = 1'b1;
               wait_cnt_d    = '0;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            // wait_cnt saturates at 2: two full WAIT cycles already spent.
            if (wait_cnt_q == 2'd2 && !bus.fifo_busy) begin
               state_d      = StDone;
               ack_d        = grant_q;
               push_count_d = push_count_q + 16'd1;
            end else if (wait_cnt_q != 2'd2) begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end
         StDone: begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = win_q;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         rr_ptr_q     <= 2'd3;
         win_q        <= '0;
         wait_cnt_q   <= '0;
         grant_q      <= '0;
         ack_q        <= '0;
         push_q       <= 1'b0;
         data_q       <= '0;
         push_count_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         win_q        <= win_d;
         wait_cnt_q   <= wait_cnt_d;
         grant_q      <= grant_d;
         ack_q        <= ack_d;
         push_q       <= push_d;
         data_q       <= data_d;
         push_count_q <= push_count_d;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.ack        = ack_q;
   assign bus.fifo_push  = push_q;
   assign bus.fifo_data  = data_q;
   assign bus.push_count = push_count_q;

endmodule
